// File: rtl/msrh_evict_buffer.sv
// L1D eviction buffer: holds dirty lines until L2 acknowledges their writeback.
// Lookups cover lines in flight, so readers never see stale L2 data.
module msrh_evict_buffer #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned PADDR_W = 56,
  parameter int unsigned LINE_W  = 512,
  localparam int unsigned TAG_W  = $clog2(ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_evict_valid,
  output logic               o_evict_ready,
  input  logic [PADDR_W-1:0] i_evict_paddr,
  input  logic [LINE_W-1:0]  i_evict_data,
  output logic               o_l2_req_valid,
  input  logic               i_l2_req_ready,
  output logic [PADDR_W-1:0] o_l2_req_paddr,
  output logic [LINE_W-1:0]  o_l2_req_data,
  output logic [TAG_W-1:0]   o_l2_req_tag,
  input  logic               i_l2_resp_valid,
  input  logic [TAG_W-1:0]   i_l2_resp_tag,
  input  logic               i_lookup_valid,
  input  logic [PADDR_W-1:0] i_lookup_paddr,
  output logic               o_lookup_hit,
  output logic [LINE_W-1:0]  o_lookup_data,
  output logic [TAG_W:0]     o_count,
  output logic               o_empty
);

  localparam int unsigned LINE_OFF = $clog2(LINE_W / 8);
  localparam int unsigned LADDR_W  = PADDR_W - LINE_OFF;

  typedef enum logic [1:0] {
    E_IDLE,
    E_SEND,
    E_WAIT_ACK
  } state_e;

  state_e             r_state   [ENTRIES];
  logic [LADDR_W-1:0] r_line    [ENTRIES];
  logic [LINE_W-1:0]  r_data    [ENTRIES];
  logic               r_dropped [ENTRIES];

  logic               w_send_any;
  logic [TAG_W-1:0]   w_send_idx;
  logic               w_l2_fire;
  logic               w_idle_any;
  logic [TAG_W-1:0]   w_idle_idx;
  logic               w_block;
  logic               w_merge;
  logic [TAG_W-1:0]   w_merge_idx;
  logic               w_accept;
  logic               w_hit;
  logic [LINE_W-1:0]  w_hit_data;
  logic [TAG_W:0]     w_count;
  logic [LADDR_W-1:0] w_evict_line;
  logic [LADDR_W-1:0] w_lookup_line;
  logic               w_unused_lsbs;

  assign w_evict_line  = i_evict_paddr[PADDR_W-1:LINE_OFF];
  assign w_lookup_line = i_lookup_paddr[PADDR_W-1:LINE_OFF];
  assign w_unused_lsbs = ^{i_evict_paddr[LINE_OFF-1:0], i_lookup_paddr[LINE_OFF-1:0]};

  always_comb begin
    w_send_any  = 1'b0;
    w_send_idx  = '0;
    w_idle_any  = 1'b0;
    w_idle_idx  = '0;
    w_count     = '0;
    w_hit       = 1'b0;
    w_hit_data  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (r_state[i] == E_SEND && !w_send_any) begin
        w_send_any = 1'b1;
        w_send_idx = TAG_W'(i);
      end
      if (r_state[i] == E_IDLE && !w_idle_any) begin
        w_idle_any = 1'b1;
        w_idle_idx = TAG_W'(i);
      end
      if (r_state[i] != E_IDLE) begin
        w_count = w_count + (TAG_W+1)'(1);
        if (r_line[i] == w_lookup_line) begin
          w_hit      = 1'b1;
          w_hit_data = r_data[i];
        end
      end
    end
  end

  assign w_l2_fire = w_send_any && i_l2_req_ready;

  // A same-line SEND entry leaving this cycle cannot absorb a merge, so it blocks like WAIT_ACK.
  always_comb begin
    w_block     = 1'b0;
    w_merge     = 1'b0;
    w_merge_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (r_state[i] != E_IDLE && r_line[i] == w_evict_line) begin
        if (r_state[i] == E_WAIT_ACK ||
            (w_l2_fire && w_send_idx == TAG_W'(i))) begin
          w_block = 1'b1;
        end else begin
          w_merge     = 1'b1;
          w_merge_idx = TAG_W'(i);
        end
      end
    end
  end

  assign o_evict_ready = !i_reset && !w_block && (w_merge || w_idle_any);
  assign w_accept      = i_evict_valid && o_evict_ready;

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (i_reset) begin
        r_state[i]   <= E_IDLE;
        r_dropped[i] <= r_dropped[i] || (r_state[i] == E_WAIT_ACK);
      end else begin
        if (w_l2_fire && w_send_idx == TAG_W'(i)) begin
          r_state[i] <= E_WAIT_ACK;
        end
        if (i_l2_resp_valid && i_l2_resp_tag == TAG_W'(i)) begin
          r_dropped[i] <= 1'b0;
          if (r_state[i] == E_WAIT_ACK) begin
            r_state[i] <= E_IDLE;
          end
        end
        if (w_accept && !w_merge && w_idle_idx == TAG_W'(i)) begin
          r_state[i]   <= E_SEND;
          r_dropped[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (w_accept && !w_merge && w_idle_idx == TAG_W'(i)) begin
        r_line[i] <= w_evict_line;
        r_data[i] <= i_evict_data;
      end else if (w_accept && w_merge && w_merge_idx == TAG_W'(i)) begin
        r_data[i] <= i_evict_data;
      end
    end
  end

  assign o_l2_req_valid = w_send_any;
  assign o_l2_req_paddr = {r_line[w_send_idx], LINE_OFF'(0)};
  assign o_l2_req_data  = r_data[w_send_idx];
  assign o_l2_req_tag   = w_send_idx;

  assign o_lookup_hit  = i_lookup_valid && w_hit;
  assign o_lookup_data = o_lookup_hit ? w_hit_data : '0;
  assign o_count       = w_count;
  assign o_empty       = (w_count == '0);

  // Acks for entries dropped by a reset are legitimate stragglers, not protocol errors.
  a_ack_in_wait: assert property (@(posedge i_clk) disable iff (i_reset)
    i_l2_resp_valid |-> (r_state[i_l2_resp_tag] == E_WAIT_ACK || r_dropped[i_l2_resp_tag]));

endmodule

// File: tb/tb_msrh_evict_buffer.sv
// Directed bench for msrh_evict_buffer: writeback flow, fill, merge, block, lookup, reset.
module tb_msrh_evict_buffer;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned PADDR_W = 56;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned TAG_W   = 2;

  localparam logic [LINE_W-1:0] D0 = {16{32'hD000_0001}};
  localparam logic [LINE_W-1:0] DA = {16{32'hAAAA_0002}};
  localparam logic [LINE_W-1:0] DB = {16{32'hBBBB_0003}};
  localparam logic [LINE_W-1:0] DC = {16{32'hCCCC_0004}};
  localparam logic [LINE_W-1:0] D5 = {16{32'h5555_0005}};
  localparam logic [LINE_W-1:0] P2 = {16{32'h2222_0006}};
  localparam logic [LINE_W-1:0] P3 = {16{32'h3333_0007}};

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_evict_valid;
  logic               o_evict_ready;
  logic [PADDR_W-1:0] i_evict_paddr;
  logic [LINE_W-1:0]  i_evict_data;
  logic               o_l2_req_valid;
  logic               i_l2_req_ready;
  logic [PADDR_W-1:0] o_l2_req_paddr;
  logic [LINE_W-1:0]  o_l2_req_data;
  logic [TAG_W-1:0]   o_l2_req_tag;
  logic               i_l2_resp_valid;
  logic [TAG_W-1:0]   i_l2_resp_tag;
  logic               i_lookup_valid;
  logic [PADDR_W-1:0] i_lookup_paddr;
  logic               o_lookup_hit;
  logic [LINE_W-1:0]  o_lookup_data;
  logic [TAG_W:0]     o_count;
  logic               o_empty;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  msrh_evict_buffer #(.ENTRIES(ENTRIES), .PADDR_W(PADDR_W), .LINE_W(LINE_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_evict_valid(i_evict_valid), .o_evict_ready(o_evict_ready),
    .i_evict_paddr(i_evict_paddr), .i_evict_data(i_evict_data),
    .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_paddr(o_l2_req_paddr), .o_l2_req_data(o_l2_req_data),
    .o_l2_req_tag(o_l2_req_tag),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_tag(i_l2_resp_tag),
    .i_lookup_valid(i_lookup_valid), .i_lookup_paddr(i_lookup_paddr),
    .o_lookup_hit(o_lookup_hit), .o_lookup_data(o_lookup_data),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_evict_valid = 1'b0; i_l2_req_ready = 1'b0;
    i_l2_resp_valid = 1'b0; i_lookup_valid = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  // Offer one line, require it to be taken this cycle, and advance one clock.
  task automatic offer(input string tag, input logic [PADDR_W-1:0] pa,
                       input logic [LINE_W-1:0] d);
    i_evict_valid = 1'b1; i_evict_paddr = pa; i_evict_data = d;
    settle();
    check(tag, LINE_W'(o_evict_ready), LINE_W'(1));
    tick();
    i_evict_valid = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_evict_valid = 1'b0; i_evict_paddr = '0; i_evict_data = '0;
    i_l2_req_ready = 1'b0; i_l2_resp_valid = 1'b0; i_l2_resp_tag = '0;
    i_lookup_valid = 1'b0; i_lookup_paddr = '0;

    // Reset state
    tick();
    i_evict_valid = 1'b1; i_evict_paddr = 56'h1000;
    i_lookup_valid = 1'b1; i_lookup_paddr = 56'h1000;
    settle();
    check("rst_ready", LINE_W'(o_evict_ready), '0);
    check("rst_req_valid", LINE_W'(o_l2_req_valid), '0);
    check("rst_hit", LINE_W'(o_lookup_hit), '0);
    check("rst_count", LINE_W'(o_count), '0);
    check("rst_empty", LINE_W'(o_empty), LINE_W'(1));
    do_reset();

    // Basic writeback
    i_evict_valid = 1'b1; i_evict_paddr = 56'h8000_0040; i_evict_data = D0;
    settle();
    check("wb_ready", LINE_W'(o_evict_ready), LINE_W'(1));
    check("wb_no_req_same_cycle", LINE_W'(o_l2_req_valid), '0);
    tick();
    i_evict_valid = 1'b0;
    settle();
    check("wb_req_valid", LINE_W'(o_l2_req_valid), LINE_W'(1));
    check("wb_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h8000_0040));
    check("wb_tag", LINE_W'(o_l2_req_tag), '0);
    check("wb_data", o_l2_req_data, D0);
    check("wb_count", LINE_W'(o_count), LINE_W'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wb_stall_valid", LINE_W'(o_l2_req_valid), LINE_W'(1));
      check("wb_stall_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h8000_0040));
      check("wb_stall_tag", LINE_W'(o_l2_req_tag), '0);
      check("wb_stall_data", o_l2_req_data, D0);
    end
    i_l2_req_ready = 1'b1;
    tick();
    i_l2_req_ready = 1'b0;
    settle();
    check("wb_sent_valid", LINE_W'(o_l2_req_valid), '0);
    check("wb_wait_count", LINE_W'(o_count), LINE_W'(1));
    check("wb_wait_empty", LINE_W'(o_empty), '0);
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = 2'd0;
    tick();
    i_l2_resp_valid = 1'b0;
    settle();
    check("wb_acked_empty", LINE_W'(o_empty), LINE_W'(1));
    check("wb_acked_count", LINE_W'(o_count), '0);

    // Fill to full, free entry 2, reuse it
    do_reset();
    offer("fill0", 56'h1010, DA);
    offer("fill1", 56'h2000, DB);
    offer("fill2", 56'h3000, DC);
    offer("fill3", 56'h4000, D0);
    settle();
    check("full_count", LINE_W'(o_count), LINE_W'(4));
    check("full_aligned_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h1000));
    check("full_tag", LINE_W'(o_l2_req_tag), '0);
    i_evict_valid = 1'b1; i_evict_paddr = 56'h5000; i_evict_data = D5;
    settle();
    check("full_ready", LINE_W'(o_evict_ready), '0);
    i_l2_req_ready = 1'b1;
    tick(); tick(); tick();
    i_l2_req_ready = 1'b0;
    settle();
    check("full_send_tag3", LINE_W'(o_l2_req_tag), LINE_W'(3));
    check("full_still_blocked", LINE_W'(o_evict_ready), '0);
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = 2'd2;
    settle();
    check("full_ack_cycle_ready", LINE_W'(o_evict_ready), '0);
    tick();
    i_l2_resp_valid = 1'b0;
    settle();
    check("full_after_ack_ready", LINE_W'(o_evict_ready), LINE_W'(1));
    check("full_after_ack_count", LINE_W'(o_count), LINE_W'(3));
    tick();
    i_evict_valid = 1'b0;
    settle();
    check("reuse_tag", LINE_W'(o_l2_req_tag), LINE_W'(2));
    check("reuse_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h5000));
    check("reuse_data", o_l2_req_data, D5);
    check("reuse_count", LINE_W'(o_count), LINE_W'(4));

    // Merge into a SEND entry
    do_reset();
    offer("merge_first", 56'h100, DA);
    offer("merge_second", 56'h120, DB);
    settle();
    check("merge_count", LINE_W'(o_count), LINE_W'(1));
    check("merge_data", o_l2_req_data, DB);
    check("merge_paddr", LINE_W'(o_l2_req_paddr), LINE_W'(56'h100));

    // Block while the same line is leaving or awaiting ack
    i_l2_req_ready = 1'b1;
    i_evict_valid = 1'b1; i_evict_paddr = 56'h100; i_evict_data = DC;
    settle();
    check("blk_handoff_ready", LINE_W'(o_evict_ready), '0);
    tick();
    i_l2_req_ready = 1'b0;
    settle();
    check("blk_wait_ready", LINE_W'(o_evict_ready), '0);
    check("blk_wait_count", LINE_W'(o_count), LINE_W'(1));
    tick();
    check("blk_wait_ready2", LINE_W'(o_evict_ready), '0);
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = 2'd0;
    settle();
    check("blk_ack_cycle_ready", LINE_W'(o_evict_ready), '0);
    tick();
    i_l2_resp_valid = 1'b0;
    settle();
    check("blk_after_ack_ready", LINE_W'(o_evict_ready), LINE_W'(1));
    tick();
    i_evict_valid = 1'b0;
    settle();
    check("blk_new_count", LINE_W'(o_count), LINE_W'(1));
    check("blk_new_valid", LINE_W'(o_l2_req_valid), LINE_W'(1));
    check("blk_new_data", o_l2_req_data, DC);

    // Lookup: 0x300 in WAIT_ACK, 0x200 in SEND
    do_reset();
    offer("lk_0x300", 56'h300, P3);
    i_l2_req_ready = 1'b1;
    offer("lk_0x200", 56'h200, P2);
    i_l2_req_ready = 1'b0;
    i_lookup_valid = 1'b1; i_lookup_paddr = 56'h23F;
    settle();
    check("lk_send_hit", LINE_W'(o_lookup_hit), LINE_W'(1));
    check("lk_send_data", o_lookup_data, P2);
    i_lookup_paddr = 56'h310;
    settle();
    check("lk_wait_hit", LINE_W'(o_lookup_hit), LINE_W'(1));
    check("lk_wait_data", o_lookup_data, P3);
    i_lookup_paddr = 56'h400;
    settle();
    check("lk_miss_hit", LINE_W'(o_lookup_hit), '0);
    check("lk_miss_data", o_lookup_data, '0);
    i_lookup_valid = 1'b0; i_lookup_paddr = 56'h200;
    settle();
    check("lk_novalid_hit", LINE_W'(o_lookup_hit), '0);
    i_lookup_valid = 1'b1; i_lookup_paddr = 56'h500;
    i_evict_valid = 1'b1; i_evict_paddr = 56'h500; i_evict_data = D5;
    settle();
    check("lk_same_cycle_hit", LINE_W'(o_lookup_hit), '0);
    check("lk_same_cycle_ready", LINE_W'(o_evict_ready), LINE_W'(1));
    tick();
    i_evict_valid = 1'b0;
    settle();
    check("lk_next_cycle_hit", LINE_W'(o_lookup_hit), LINE_W'(1));
    check("lk_next_cycle_data", o_lookup_data, D5);

    // Reset mid-flight: entries 0,1 WAIT_ACK, entry 2 SEND
    i_l2_req_ready = 1'b1;
    tick();
    i_l2_req_ready = 1'b0;
    settle();
    check("mid_count", LINE_W'(o_count), LINE_W'(3));
    check("mid_send_tag", LINE_W'(o_l2_req_tag), LINE_W'(2));
    i_reset = 1'b1; i_evict_valid = 1'b1; i_evict_paddr = 56'h900;
    settle();
    check("mid_rst_ready", LINE_W'(o_evict_ready), '0);
    tick();
    i_reset = 1'b0; i_evict_valid = 1'b0; i_lookup_paddr = 56'h200;
    settle();
    check("mid_post_count", LINE_W'(o_count), '0);
    check("mid_post_empty", LINE_W'(o_empty), LINE_W'(1));
    check("mid_post_req_valid", LINE_W'(o_l2_req_valid), '0);
    check("mid_post_hit", LINE_W'(o_lookup_hit), '0);
    i_l2_resp_valid = 1'b1; i_l2_resp_tag = 2'd1;
    tick();
    i_l2_resp_valid = 1'b0;
    settle();
    check("stale_ack_count", LINE_W'(o_count), '0);
    check("stale_ack_empty", LINE_W'(o_empty), LINE_W'(1));
    offer("post_rst_offer", 56'hA00, DA);
    settle();
    check("post_rst_tag", LINE_W'(o_l2_req_tag), '0);
    check("post_rst_count", LINE_W'(o_count), LINE_W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
